dac_spi_responder: RTL and testbench
====================================

# dac_spi_responder

SPI responder (slave) side of the DAC serial link: receives 24-bit frames on SCK/CSn/SDI, maintains the input and DAC registers of a 16-bit voltage-output DAC, honours LDAc and CLRn, and returns status and the DAC register on SDO. Used as the synthesizable DAC emulator on the far end of the existing DAC SPI master: in loopback builds on the board FPGA, and as the reference model in system benches. All pins are oversampled in the `clk` domain; there is no SCK clock domain.

## Interface
- `FRAME_BITS`, 24: bits per valid frame.
- `CLEAR_CODE`, 16'h0000: code forced into both registers by CLRn.
- `clk`  in  1  system clock. One clock.
- `rst_l`  in  1  asynchronous, active-low reset.
- `SCK`  in  1  serial clock from master (idle low).
- `CSn`  in  1  frame select, active low.
- `SDI`  in  1  serial data, master to responder.
- `LDAc`  in  1  load DAC, active low; falling edge acts.
- `CLRn`  in  1  clear, active low, level-sensitive.
- `SDO`  out  1  serial data, responder to master.
- `dac_code`  out  16  DAC register (emulated analog output).
- `dac_update`  out  1  one-cycle pulse when `dac_code` changes by a load or clear edge.
- `frame_valid`  out  1  one-cycle pulse when a correctly sized frame executes.
- `frame_err`  out  1  one-cycle pulse when a frame is discarded.

## Operation
- All five pin inputs pass through a 2-FF synchronizer, then a registered edge detector.
- Frame layout, MSB first: [23:20] cmd, [19:16] reserved (ignored), [15:0] data.
- Commands: 4'h1 write input register; 4'h2 copy input to DAC register (data ignored); 4'h3 write input and DAC registers; 4'h0 no-op (readback only). Other codes: frame is counted valid, no register change.
- Synced CSn falling edge: bit counter := 0; tx shift register := {4'hA, 3'b000, err_sticky, dac_reg}; err_sticky := 0.
- Synced SCK rising edge while CSn low: shift SDI into rx register LSB; bit counter increments, saturating at 31.
- Synced SCK falling edge while CSn low: tx register shifts left; SDO = tx[23].
- SDO = tx[23] while CSn low, 0 while CSn high (always driven).
- Synced CSn rising edge: counter == FRAME_BITS -> execute command, pulse `frame_valid`; else pulse `frame_err`, set err_sticky, no register change.
- LDAc falling edge while CSn high: DAC register := input register, pulse `dac_update`. While CSn low: ignored.
- CLRn low: both registers held at CLEAR_CODE; `dac_update` pulses once on entry to clear; writes and loads are suppressed while low.

## Timing
- Reset: `SDO`=0, `dac_code`=CLEAR_CODE, input register=CLEAR_CODE, all pulses 0, err_sticky=0, counter=0, synchronizers to idle (SCK=0, CSn=1, LDAc=1, CLRn=1).
- Pin-to-action latency: 3 `clk` cycles (2 sync + 1 edge register); `dac_code` updates and pulses assert in the same cycle.
- Master requirements: SCK high and low each ≥ 3 `clk`; CSn setup to first SCK rise ≥ 3 `clk`; SDO valid for master sampling 4 `clk` after SCK fall.
- Simultaneous frame execute and LDAc edge in the same cycle: write is applied first, and LDAc loads the newly written input value.
- CLRn asserted with frame execute or LDAc in the same cycle: clear wins; the frame still pulses `frame_valid` or `frame_err` as usual.
- Reset mid-frame: partial frame discarded, no pulses.
- Over-length frame (>24 bits): counter saturates; discarded as error.

## Structure
- Package `dac_spi_pkg`: FRAME_BITS default, command codes (CMD_NOP, CMD_WR_IN, CMD_UPD, CMD_WR_UPD), ID nibble 4'hA, field bit positions.
- Sub-module `sync_edge`: 2-FF synchronizer plus rise/fall pulses with reset idle value as parameter; instantiated five times.
- Top holds counter, rx/tx shift registers, input and DAC registers, and sticky error.

## Test plan
- Reset, then frame 24'h3_0_ABCD (CMD_WR_UPD) -> `dac_code`=16'hABCD, one `frame_valid`, one `dac_update`.
- 24'h1_0_1234, then LDAc low pulse with CSn high -> `dac_code` unchanged until LDAc; then 16'h1234 three cycles after the edge.
- 23-bit frame, then 25-bit frame -> two `frame_err` pulses, registers unchanged; the next frame's SDO first byte = 8'hA1, and the following frame's = 8'hA0.
- After `dac_code`=16'h5A5A, no-op frame -> SDO returns 24'hA0_5A5A bit-exact.
- CLRn low during 24'h3_0_FFFF execute -> `dac_code`=16'h0000; writes are ignored until CLRn rises.
- LDAc edge mid-frame and rst_l asserted mid-frame -> no load occurs; after reset all outputs are at reset values and the next full frame executes normally.

Source files
------------

// File: rtl/dac_spi_responder_pkg.sv
// Shared constants and types for the DAC SPI responder.
// No logic of its own; frame layout, command codes and the status word builder.
// No flow control; the master paces every transfer.
package dac_spi_pkg;

  localparam int          FRAME_BITS_DEF = 24;
  localparam int          DATA_W         = 16;
  localparam logic [15:0] CLEAR_CODE_DEF = 16'h0000;

  // Frame bit positions, MSB first on the wire
  localparam int SHIFT_W  = 24;
  localparam int CMD_MSB  = 23;
  localparam int CMD_LSB  = 20;
  localparam int DATA_MSB = 15;

  // Bit counter saturates so over-length frames can never alias to a valid length
  localparam int               CNT_W   = 5;
  localparam logic [CNT_W-1:0] CNT_MAX = 5'd31;

  localparam logic [3:0] ID_NIBBLE = 4'hA;

  typedef enum logic [3:0] {
    CMD_NOP    = 4'h0,
    CMD_WR_IN  = 4'h1,
    CMD_UPD    = 4'h2,
    CMD_WR_UPD = 4'h3
  } cmd_e;

  // Word returned on SDO during the next frame: ID, sticky error, DAC register
  function automatic logic [SHIFT_W-1:0] status_word(input logic err,
                                                     input logic [DATA_W-1:0] dac);
    return {ID_NIBBLE, 3'b000, err, dac};
  endfunction

endpackage

// File: rtl/dac_spi_responder_if.sv
// Pin bundle between the DAC SPI master and the responder.
// Pure wiring, no latency.
// No flow control; the master owns SCK/CSn timing.
interface dac_spi_responder_if;
  import dac_spi_pkg::*;

  logic              SCK;
  logic              CSn;
  logic              SDI;
  logic              LDAc;
  logic              CLRn;
  logic              SDO;
  logic [DATA_W-1:0] dac_code;
  logic              dac_update;
  logic              frame_valid;
  logic              frame_err;

  modport master (
    output SCK, CSn, SDI, LDAc, CLRn,
    input  SDO, dac_code, dac_update, frame_valid, frame_err
  );

  modport slave (
    input  SCK, CSn, SDI, LDAc, CLRn,
    output SDO, dac_code, dac_update, frame_valid, frame_err
  );

endinterface

// File: rtl/dac_spi_responder_sync_edge.sv
// Two-flop synchronizer for one asynchronous pin plus rise/fall detection.
// Level is 2 clk behind the pin; rise/fall are combinational off the third flop.
// No flow control; every pin transition is reported exactly once.
module sync_edge #(
  parameter logic IDLE = 1'b0
) (
  input  logic clk,
  input  logic rst_l,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  // Shift the pin through the synchronizer and keep one cycle of history
  always_comb begin
    meta_d = din;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Reset to the pin's idle level so release never looks like an edge
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      meta_q <= IDLE;
      sync_q <= IDLE;
      prev_q <= IDLE;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign lvl  = sync_q;
  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/dac_spi_responder.sv
// SPI responder emulating a 16-bit DAC: input/DAC registers, LDAc load, CLRn clear, status readback.
// Pin-to-action latency 3 clk; pulses and dac_code update in the same cycle.
// No flow control; master must keep SCK phases and CSn setup at least 3 clk.
module dac_spi_responder
  import dac_spi_pkg::*;
#(
  parameter int          FRAME_BITS = FRAME_BITS_DEF,
  parameter logic [15:0] CLEAR_CODE = CLEAR_CODE_DEF
) (
  input logic              clk,
  input logic              rst_l,
  dac_spi_responder_if.slave bus
);

  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_BITS);

  logic sck_lvl, sck_rise, sck_fall;
  logic cs_lvl,  cs_rise,  cs_fall;
  logic sdi_lvl, sdi_rise, sdi_fall;
  logic ld_lvl,  ld_rise,  ld_fall;
  logic clr_lvl, clr_rise, clr_fall;

  sync_edge #(.IDLE(1'b0)) u_sck (
    .clk(clk), .rst_l(rst_l), .din(bus.SCK),
    .lvl(sck_lvl), .rise(sck_rise), .fall(sck_fall)
  );

  sync_edge #(.IDLE(1'b1)) u_cs (
    .clk(clk), .rst_l(rst_l), .din(bus.CSn),
    .lvl(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  sync_edge #(.IDLE(1'b0)) u_sdi (
    .clk(clk), .rst_l(rst_l), .din(bus.SDI),
    .lvl(sdi_lvl), .rise(sdi_rise), .fall(sdi_fall)
  );

  sync_edge #(.IDLE(1'b1)) u_ld (
    .clk(clk), .rst_l(rst_l), .din(bus.LDAc),
    .lvl(ld_lvl), .rise(ld_rise), .fall(ld_fall)
  );

  sync_edge #(.IDLE(1'b1)) u_clr (
    .clk(clk), .rst_l(rst_l), .din(bus.CLRn),
    .lvl(clr_lvl), .rise(clr_rise), .fall(clr_fall)
  );

  // Edge outputs this block has no use for
  logic unused_edges;
  assign unused_edges = ^{sck_lvl, sdi_rise, sdi_fall, ld_lvl, ld_rise, clr_rise};

  logic [CNT_W-1:0]   bit_cnt_q,     bit_cnt_d;
  logic [SHIFT_W-1:0] rx_q,          rx_d;
  logic [SHIFT_W-1:0] tx_q,          tx_d;
  logic [DATA_W-1:0]  in_reg_q,      in_reg_d;
  logic [DATA_W-1:0]  dac_reg_q,     dac_reg_d;
  logic               err_sticky_q,  err_sticky_d;
  logic               sdo_q,         sdo_d;
  logic               dac_update_q,  dac_update_d;
  logic               frame_valid_q, frame_valid_d;
  logic               frame_err_q,   frame_err_d;

  // Frame shifting, command execution, LDAc load and clear, in priority order
  always_comb begin
    bit_cnt_d     = bit_cnt_q;
    rx_d          = rx_q;
    tx_d          = tx_q;
    in_reg_d      = in_reg_q;
    dac_reg_d     = dac_reg_q;
    err_sticky_d  = err_sticky_q;
    dac_update_d  = 1'b0;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;

    // Frame start: snapshot status for readback, then forget the old error
    if (cs_fall) begin
      bit_cnt_d    = '0;
      tx_d         = status_word(err_sticky_q, dac_reg_q);
      err_sticky_d = 1'b0;
    end

    if (!cs_lvl && sck_rise) begin
      rx_d = {rx_q[SHIFT_W-2:0], sdi_lvl};
      if (bit_cnt_q != CNT_MAX) begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end

    if (!cs_lvl && sck_fall) begin
      tx_d = {tx_q[SHIFT_W-2:0], 1'b0};
    end

    // Frame end: only an exact-length frame may touch the registers
    if (cs_rise) begin
      if (bit_cnt_q == FRAME_CNT) begin
        frame_valid_d = 1'b1;
        case (cmd_e'(rx_q[CMD_MSB:CMD_LSB]))
          CMD_WR_IN: begin
            in_reg_d = rx_q[DATA_MSB:0];
          end
          CMD_UPD: begin
            dac_reg_d    = in_reg_q;
            dac_update_d = 1'b1;
          end
          CMD_WR_UPD: begin
            in_reg_d     = rx_q[DATA_MSB:0];
            dac_reg_d    = rx_q[DATA_MSB:0];
            dac_update_d = 1'b1;
          end
          CMD_NOP: begin
          end
          default: begin
          end
        endcase
      end else begin
        frame_err_d  = 1'b1;
        err_sticky_d = 1'b1;
      end
    end

    // LDAc sees a write from the frame ending this same cycle
    if (ld_fall && cs_lvl) begin
      dac_reg_d    = in_reg_d;
      dac_update_d = 1'b1;
    end

    // Clear overrides everything above; only its entry counts as an update
    if (!clr_lvl) begin
      in_reg_d     = CLEAR_CODE;
      dac_reg_d    = CLEAR_CODE;
      dac_update_d = clr_fall;
    end

    sdo_d = cs_lvl ? 1'b0 : tx_d[SHIFT_W-1];
  end

  // State registers
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      bit_cnt_q     <= '0;
      rx_q          <= '0;
      tx_q          <= '0;
      in_reg_q      <= CLEAR_CODE;
      dac_reg_q     <= CLEAR_CODE;
      err_sticky_q  <= 1'b0;
      sdo_q         <= 1'b0;
      dac_update_q  <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      bit_cnt_q     <= bit_cnt_d;
      rx_q          <= rx_d;
      tx_q          <= tx_d;
      in_reg_q      <= in_reg_d;
      dac_reg_q     <= dac_reg_d;
      err_sticky_q  <= err_sticky_d;
      sdo_q         <= sdo_d;
      dac_update_q  <= dac_update_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign bus.SDO         = sdo_q;
  assign bus.dac_code    = dac_reg_q;
  assign bus.dac_update  = dac_update_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_err   = frame_err_q;

endmodule

// File: tb/tb_dac_spi_responder.sv
// Directed bench for dac_spi_responder with an event-level DAC model.
// Pin events are scheduled to take effect 3 clk after they are driven.
// Master timing: SCK phases 4-5 clk, CSn setup 4 clk, SDO sampled 5 clk after SCK fall.
module tb_dac_spi_responder;
  import dac_spi_pkg::*;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  dac_spi_responder_if bus_if();

  dac_spi_responder #(.FRAME_BITS(24), .CLEAR_CODE(16'h0000)) dut (
    .clk(clk),
    .rst_l(rst_l),
    .bus(bus_if)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model of the emulated DAC as the pins describe it
  logic [15:0] m_in = 16'h0;
  logic [15:0] m_dac = 16'h0;
  bit          m_sticky = 1'b0;
  bit          m_clr = 1'b0;

  localparam int EV_FRAME = 0, EV_LDAC = 1, EV_CLR_ON = 2, EV_CLR_OFF = 3;

  typedef struct {
    int          due;
    int          kind;
    logic [23:0] frame;
    int          nbits;
    bit          cs_high;
  } ev_t;

  ev_t evq[$];

  task automatic post(input int kind, input logic [23:0] frame, input int nbits, input bit cs_high);
    ev_t e;
    e.due = cyc + 3;
    e.kind = kind;
    e.frame = frame;
    e.nbits = nbits;
    e.cs_high = cs_high;
    evq.push_back(e);
  endtask

  // Returns {frame_valid, frame_err, dac_update} expected from one event
  function automatic logic [2:0] apply_ev(input ev_t e);
    logic fv, fe, upd;
    fv = 1'b0; fe = 1'b0; upd = 1'b0;
    case (e.kind)
      EV_FRAME: begin
        if (e.nbits == 24) begin
          fv = 1'b1;
          if (!m_clr) begin
            case (e.frame[23:20])
              4'h1: m_in = e.frame[15:0];
              4'h2: begin m_dac = m_in; upd = 1'b1; end
              4'h3: begin m_in = e.frame[15:0]; m_dac = e.frame[15:0]; upd = 1'b1; end
              default: ;
            endcase
          end
        end else begin
          fe = 1'b1;
          m_sticky = 1'b1;
        end
      end
      EV_LDAC: if (e.cs_high && !m_clr) begin m_dac = m_in; upd = 1'b1; end
      EV_CLR_ON: begin m_clr = 1'b1; m_in = 16'h0; m_dac = 16'h0; upd = 1'b1; end
      EV_CLR_OFF: m_clr = 1'b0;
      default: ;
    endcase
    return {fv, fe, upd};
  endfunction

  int n_fv = 0, n_fe = 0, n_upd = 0;
  logic [2:0] e_p;

  // Per-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (rst_l) begin
      e_p = 3'b000;
      for (int k = 0; k < 4; k++)
        foreach (evq[i])
          if (evq[i].due == cyc && evq[i].kind == k) e_p = e_p | apply_ev(evq[i]);
      for (int i = evq.size() - 1; i >= 0; i--)
        if (evq[i].due <= cyc) evq.delete(i);
      chk("dac_code", bus_if.dac_code, m_dac);
      chk("frame_valid", bus_if.frame_valid, e_p[2]);
      chk("frame_err", bus_if.frame_err, e_p[1]);
      chk("dac_update", bus_if.dac_update, e_p[0]);
      if (bus_if.frame_valid) n_fv++;
      if (bus_if.frame_err) n_fe++;
      if (bus_if.dac_update) n_upd++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clock_bit(input logic b, output logic sdo_bit);
    bus_if.SDI = b;
    sdo_bit = bus_if.SDO;
    tick(1);
    bus_if.SCK = 1'b1;
    tick(4);
    bus_if.SCK = 1'b0;
    tick(5);
  endtask

  task automatic send_frame(input logic [31:0] bits, input int nbits, input int ld_bit,
                            input bit ld_at_end, output logic [23:0] rb);
    logic [23:0] exp_rb;
    logic s;
    exp_rb = {4'hA, 3'b000, m_sticky, m_dac};
    m_sticky = 1'b0;
    rb = '0;
    bus_if.CSn = 1'b0;
    tick(4);
    for (int i = 0; i < nbits; i++) begin
      if (i == ld_bit) begin
        bus_if.LDAc = 1'b0;
        post(EV_LDAC, '0, 0, 1'b0);
      end
      clock_bit(bits[nbits-1-i], s);
      if (i == ld_bit) bus_if.LDAc = 1'b1;
      if (i < 24) rb = {rb[22:0], s};
    end
    bus_if.CSn = 1'b1;
    post(EV_FRAME, bits[23:0], nbits, 1'b1);
    if (ld_at_end) begin
      bus_if.LDAc = 1'b0;
      post(EV_LDAC, '0, 0, 1'b1);
    end
    tick(4);
    bus_if.LDAc = 1'b1;
    tick(6);
    if (nbits >= 24) chk("sdo_readback", rb, exp_rb);
  endtask

  task automatic ldac_pulse();
    bus_if.LDAc = 1'b0;
    post(EV_LDAC, '0, 0, bus_if.CSn);
    tick(4);
    bus_if.LDAc = 1'b1;
    tick(6);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_sdo"}, bus_if.SDO, 1'b0);
    chk({tag, "_dac_code"}, bus_if.dac_code, 16'h0000);
    chk({tag, "_dac_update"}, bus_if.dac_update, 1'b0);
    chk({tag, "_frame_valid"}, bus_if.frame_valid, 1'b0);
    chk({tag, "_frame_err"}, bus_if.frame_err, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [23:0] rb;
    logic s;
    bus_if.SCK = 1'b0; bus_if.CSn = 1'b1; bus_if.SDI = 1'b0;
    bus_if.LDAc = 1'b1; bus_if.CLRn = 1'b1;
    rst_l = 1'b0;
    tick(3);
    check_reset_outputs("reset");
    rst_l = 1'b1;
    tick(4);

    // Write input and DAC together
    send_frame(32'h0030ABCD, 24, -1, 1'b0, rb);
    chk("wr_upd_code", bus_if.dac_code, 16'hABCD);
    chk("wr_upd_fv_count", n_fv, 1);
    chk("wr_upd_upd_count", n_upd, 1);

    // Write input only, then load with LDAc; pin the 3-cycle latency
    send_frame(32'h00101234, 24, -1, 1'b0, rb);
    chk("wr_in_hold", bus_if.dac_code, 16'hABCD);
    bus_if.LDAc = 1'b0;
    post(EV_LDAC, '0, 0, 1'b1);
    tick(2);
    chk("ldac_before", bus_if.dac_code, 16'hABCD);
    tick(1);
    chk("ldac_after", bus_if.dac_code, 16'h1234);
    tick(2);
    bus_if.LDAc = 1'b1;
    tick(6);
    chk("ldac_upd_count", n_upd, 2);

    // Short and long frames are discarded and leave the sticky error
    send_frame(32'h0030BEEF, 23, -1, 1'b0, rb);
    send_frame(32'h0130BEEF, 25, -1, 1'b0, rb);
    chk("err_count", n_fe, 2);
    chk("err_hold", bus_if.dac_code, 16'h1234);
    send_frame(32'h00000000, 24, -1, 1'b0, rb);
    chk("sticky_byte", rb[23:16], 8'hA1);
    send_frame(32'h00000000, 24, -1, 1'b0, rb);
    chk("cleared_byte", rb[23:16], 8'hA0);

    // Readback of the DAC register
    send_frame(32'h00305A5A, 24, -1, 1'b0, rb);
    send_frame(32'h00000000, 24, -1, 1'b0, rb);
    chk("readback_5a5a", rb, 24'hA05A5A);

    // Frame end and LDAc edge together: LDAc takes the fresh write
    send_frame(32'h00107777, 24, -1, 1'b1, rb);
    chk("simul_ldac", bus_if.dac_code, 16'h7777);

    // Clear: forced code, writes and loads suppressed while low
    bus_if.CLRn = 1'b0;
    post(EV_CLR_ON, '0, 0, 1'b1);
    tick(6);
    chk("clr_entry", bus_if.dac_code, 16'h0000);
    send_frame(32'h0030FFFF, 24, -1, 1'b0, rb);
    chk("clr_write", bus_if.dac_code, 16'h0000);
    ldac_pulse();
    chk("clr_ldac", bus_if.dac_code, 16'h0000);
    bus_if.CLRn = 1'b1;
    post(EV_CLR_OFF, '0, 0, 1'b1);
    tick(6);
    chk("clr_release", bus_if.dac_code, 16'h0000);
    send_frame(32'h00304321, 24, -1, 1'b0, rb);
    chk("post_clr_write", bus_if.dac_code, 16'h4321);

    // LDAc falling while CSn low must not load
    send_frame(32'h00100BEE, 24, 10, 1'b0, rb);
    chk("mid_frame_ldac", bus_if.dac_code, 16'h4321);
    ldac_pulse();
    chk("later_ldac", bus_if.dac_code, 16'h0BEE);

    // Reset in the middle of a frame
    bus_if.CSn = 1'b0;
    tick(4);
    for (int i = 0; i < 8; i++) clock_bit(1'b1, s);
    rst_l = 1'b0;
    evq.delete();
    m_in = 16'h0; m_dac = 16'h0; m_sticky = 1'b0; m_clr = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    bus_if.CSn = 1'b1; bus_if.SCK = 1'b0; bus_if.SDI = 1'b0;
    tick(3);
    rst_l = 1'b1;
    tick(4);
    send_frame(32'h00301357, 24, -1, 1'b0, rb);
    chk("after_reset_rb", rb, 24'hA00000);
    chk("after_reset_code", bus_if.dac_code, 16'h1357);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
